rsa_decrypt_engine: RTL and testbench

- Sequential receiver-side RSA decryptor: computes plain = cipher^d mod n.
- Uses left-to-right square-and-multiply over a bit-serial modular multiplier; no wide `**` or `%` operators.
- Accepts one ciphertext word per valid/ready transaction; returns plaintext on a valid/ready output port.
- Sits after the link receive path and replaces the combinational decryptor in the receive chain.

---
 rtl/rsa_pkg.sv | 15 +
 rtl/rsa_modmul_seq.sv | 76 +++++++
 rtl/rsa_decrypt_engine.sv | 146 ++++++++++++++
 tb/tb_rsa_decrypt_engine.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA engine definitions: default word width and controller state encoding.
package rsa_pkg;

    localparam int RSA_W = 26;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        SQR  = 3'd2,
        MUL  = 3'd3,
        OUT  = 3'd4,
        ERR  = 3'd5
    } rsa_state_e;

endpackage

// File: rtl/rsa_modmul_seq.sv
// Interleaved MSB-first shift-add modular multiplier: r = a*b mod n, one b bit per cycle.
// Occupies W+1 cycles (start + W iterations); r is valid while done is high.
module rsa_modmul_seq
    import rsa_pkg::*;
#(
    parameter int W = RSA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] r
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  a_q, a_d, b_q, b_d, n_q, n_d, r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    dbl_w, sum_w;
    logic [W-1:0]  dbl_r, step_r;

    // Both temporaries stay below 2n, so a single conditional subtract reduces them.
    always_comb begin
        dbl_w  = {r_q, 1'b0};
        dbl_r  = (dbl_w >= {1'b0, n_q}) ? W'(dbl_w - {1'b0, n_q}) : dbl_w[W-1:0];
        sum_w  = {1'b0, dbl_r} + {1'b0, a_q};
        step_r = dbl_r;
        if (b_q[W-1]) begin
            step_r = (sum_w >= {1'b0, n_q}) ? W'(sum_w - {1'b0, n_q}) : sum_w[W-1:0];
        end
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        n_d   = n_q;
        r_d   = r_q;
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            r_d   = step_r;
            b_d   = {b_q[W-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
        end else if (start) begin
            a_d   = a;
            b_d   = b;
            n_d   = n;
            r_d   = '0;
            cnt_d = CW'(W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            n_q   <= n_d;
            r_q   <= r_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CW'(1));
    assign r    = step_r;

endmodule

// File: rtl/rsa_decrypt_engine.sv
// Receive-side RSA decryptor: plain = cipher^d mod n by constant-time left-to-right
// square-and-multiply over the sequential modular multiplier.
//   state | meaning
//   IDLE  | ready for a new cipher/d/n
//   INIT  | acc=1, bit index at MSB
//   SQR   | acc_sq = acc*acc mod n
//   MUL   | acc = d[k] ? acc_sq*base mod n : acc_sq
//   OUT   | result held until out_ready
//   ERR   | bad operands, report err
module rsa_decrypt_engine
    import rsa_pkg::*;
#(
    parameter int W = RSA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] cipher,
    input  logic [W-1:0] d,
    input  logic [W-1:0] n,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] plain,
    output logic         err
);

    localparam int KW = (W > 1) ? $clog2(W) : 1;

    rsa_state_e    state_q, state_d;
    logic [W-1:0]  base_q, base_d, d_q, d_d, n_q, n_d;
    logic [W-1:0]  acc_q, acc_d, acc_sq_q, acc_sq_d, plain_q, plain_d;
    logic          err_q, err_d;
    logic [KW-1:0] k_q, k_d;

    logic          mm_start, mm_busy, mm_done;
    logic [W-1:0]  mm_a, mm_b, mm_r;
    logic          op_bad;

    assign op_bad = (n < W'(2)) || (cipher >= n);

    rsa_modmul_seq #(.W(W)) u_modmul (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .n     (n_q),
        .busy  (mm_busy),
        .done  (mm_done),
        .r     (mm_r)
    );

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        d_d      = d_q;
        n_d      = n_q;
        acc_d    = acc_q;
        acc_sq_d = acc_sq_q;
        plain_d  = plain_q;
        err_d    = err_q;
        k_d      = k_q;
        mm_start = 1'b0;
        mm_a     = acc_q;
        mm_b     = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    base_d  = cipher;
                    d_d     = d;
                    n_d     = n;
                    state_d = op_bad ? ERR : INIT;
                end
            end
            INIT: begin
                acc_d   = W'(1);
                k_d     = KW'(W - 1);
                state_d = SQR;
            end
            SQR: begin
                mm_start = !mm_busy;
                if (mm_done) begin
                    acc_sq_d = mm_r;
                    state_d  = MUL;
                end
            end
            MUL: begin
                // The multiply always runs so timing does not leak exponent bits.
                mm_a     = acc_sq_q;
                mm_b     = base_q;
                mm_start = !mm_busy;
                if (mm_done) begin
                    acc_d = d_q[k_q] ? mm_r : acc_sq_q;
                    if (k_q == '0) begin
                        plain_d = acc_d;
                        err_d   = 1'b0;
                        state_d = OUT;
                    end else begin
                        k_d     = k_q - KW'(1);
                        state_d = SQR;
                    end
                end
            end
            ERR: begin
                plain_d = '0;
                err_d   = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            d_q      <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            acc_sq_q <= '0;
            plain_q  <= '0;
            err_q    <= 1'b0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            d_q      <= d_d;
            n_q      <= n_d;
            acc_q    <= acc_d;
            acc_sq_q <= acc_sq_d;
            plain_q  <= plain_d;
            err_q    <= err_d;
            k_q      <= k_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign plain     = plain_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rsa_decrypt_engine.sv
// Randomized self-checking bench for rsa_decrypt_engine at W=26 and W=8 against a
// plain-arithmetic modular exponentiation model.
module tb_rsa_decrypt_engine;

    localparam int WB = 26;
    localparam int WS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          iv_b, ir_b, ov_b, or_b, e_b;
    logic [WB-1:0] c_b, d_b, n_b, p_b;
    logic          iv_s, ir_s, ov_s, or_s, e_s;
    logic [WS-1:0] c_s, d_s, n_s, p_s;

    rsa_decrypt_engine #(.W(WB)) u_big (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .cipher(c_b), .d(d_b), .n(n_b),
        .out_valid(ov_b), .out_ready(or_b), .plain(p_b), .err(e_b)
    );

    rsa_decrypt_engine #(.W(WS)) u_small (
        .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir_s), .cipher(c_s), .d(d_s), .n(n_s),
        .out_valid(ov_s), .out_ready(or_s), .plain(p_s), .err(e_s)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned ref_exp(input longint unsigned c, input longint unsigned e,
                                                input longint unsigned m);
        longint unsigned r = 1;
        longint unsigned b = c % m;
        while (e != 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return r % m;
    endfunction

    task automatic drive_in(input bit sm, input bit v, input logic [25:0] c, input logic [25:0] dd,
                            input logic [25:0] nn);
        if (sm) begin
            iv_s = v; c_s = c[WS-1:0]; d_s = dd[WS-1:0]; n_s = nn[WS-1:0];
        end else begin
            iv_b = v; c_b = c; d_b = dd; n_b = nn;
        end
    endtask

    task automatic set_or(input bit sm, input bit v);
        if (sm) or_s = v; else or_b = v;
    endtask

    function automatic bit get_ov(input bit sm); return sm ? ov_s : ov_b; endfunction
    function automatic bit get_ir(input bit sm); return sm ? ir_s : ir_b; endfunction
    function automatic bit get_e(input bit sm);  return sm ? e_s : e_b;  endfunction
    function automatic logic [25:0] get_p(input bit sm);
        return sm ? {18'd0, p_s} : p_b;
    endfunction

    task automatic xact(input bit sm, input logic [25:0] c, input logic [25:0] dd,
                        input logic [25:0] nn, input int hold, input bit toggle, input string tag);
        int              w, lat, exp_lat;
        bit              exp_e, rdy_seen, stable;
        longint unsigned exp_p;
        logic [25:0]     p0;
        logic            e0;
        w       = sm ? WS : WB;
        exp_e   = (nn < 2) || (c >= nn);
        exp_p   = exp_e ? 0 : ref_exp(c, dd, nn);
        exp_lat = exp_e ? 2 : 2 + 2 * w * (w + 1);
        @(negedge clk);
        chk({tag, " idle_ready"}, get_ir(sm), 1);
        drive_in(sm, 1'b1, c, dd, nn);
        @(negedge clk);
        drive_in(sm, 1'b0, '0, '0, '0);
        lat = 1;
        rdy_seen = 0;
        while (!get_ov(sm) && lat < 3000) begin
            if (get_ir(sm)) rdy_seen = 1;
            if (toggle) drive_in(sm, 1'($urandom_range(0, 1)), 26'($urandom), 26'($urandom), 26'($urandom));
            @(negedge clk);
            lat++;
        end
        drive_in(sm, 1'b0, '0, '0, '0);
        chk({tag, " latency"}, lat, exp_lat);
        p0 = get_p(sm);
        e0 = get_e(sm);
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            if (get_ir(sm)) rdy_seen = 1;
            if (toggle) drive_in(sm, 1'b1, 26'd1, 26'd1, 26'd33);
            if (!get_ov(sm) || get_p(sm) !== p0 || get_e(sm) !== e0) stable = 0;
            @(negedge clk);
        end
        drive_in(sm, 1'b0, '0, '0, '0);
        if (hold > 0) chk({tag, " hold_stable"}, stable, 1);
        chk({tag, " plain"}, get_p(sm), exp_p);
        chk({tag, " err"}, get_e(sm), exp_e);
        if (get_ir(sm)) rdy_seen = 1;
        chk({tag, " busy_ready_low"}, rdy_seen, 0);
        set_or(sm, 1'b1);
        @(negedge clk);
        set_or(sm, 1'b0);
        chk({tag, " ov_after_hs"}, get_ov(sm), 0);
        chk({tag, " ir_after_hs"}, get_ir(sm), 1);
    endtask

    initial begin
        logic [25:0] rn, rc, rd;
        iv_b = 0; c_b = '0; d_b = '0; n_b = '0; or_b = 0;
        iv_s = 0; c_s = '0; d_s = '0; n_s = '0; or_s = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst in_ready", ir_b, 1);
        chk("rst out_valid", ov_b, 0);
        chk("rst plain", p_b, 0);
        chk("rst err", e_b, 0);
        chk("rst8 in_ready", ir_s, 1);
        chk("rst8 out_valid", ov_s, 0);
        rst = 0;

        xact(0, 26'd31, 26'd7, 26'd33, 0, 0, "n33");
        xact(0, 26'd2790, 26'd2753, 26'd3233, 0, 0, "n3233_dec");
        xact(0, 26'd65, 26'd17, 26'd3233, 0, 0, "n3233_enc");
        xact(0, 26'd0, 26'd5, 26'd1, 0, 0, "err_n1");
        xact(0, 26'd40, 26'd7, 26'd33, 3, 0, "err_c_ge_n");
        xact(0, 26'd31, 26'd7, 26'd33, 10, 1, "backpressure");
        xact(0, 26'd5, 26'd9, 26'h3FFFFFF, 0, 0, "n_all_ones");

        @(negedge clk);
        drive_in(0, 1'b1, 26'd2790, 26'd2753, 26'd3233);
        @(negedge clk);
        drive_in(0, 1'b0, '0, '0, '0);
        repeat (499) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid out_valid", ov_b, 0);
        chk("rst_mid in_ready", ir_b, 1);
        xact(0, 26'd31, 26'd7, 26'd33, 0, 0, "after_rst");

        xact(1, 26'd200, 26'd0, 26'd255, 0, 0, "w8_d0");
        xact(1, 26'd0, 26'd255, 26'd255, 0, 0, "w8_c0");
        xact(1, 26'd2, 26'd250, 26'd251, 0, 0, "w8_fermat");
        xact(1, 26'd1, 26'd123, 26'd200, 0, 0, "w8_c1");

        for (int i = 0; i < 8; i++) begin
            rn = 26'($urandom_range(2, (1 << 26) - 1));
            rc = 26'($urandom_range(0, int'(rn) - 1));
            rd = 26'($urandom);
            xact(0, rc, rd, rn, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), "rand26");
        end
        for (int i = 0; i < 25; i++) begin
            rn = 26'($urandom_range(0, 255));
            rc = 26'($urandom_range(0, 255));
            rd = 26'($urandom_range(0, 255));
            xact(1, rc, rd, rn, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand8");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
